sha256_padder: RTL and testbench
================================

# sha256_padder

Message formatter directly upstream of the unrolled SHA-256 core. Accepts an arbitrary-length message as a stream of 32-bit big-endian words and emits complete 512-bit blocks padded per FIPS 180-4: data, one 0x80 byte, zero fill, then a 64-bit bit-length. Output blocks use the core's `message` layout, so they can drive it directly. Each block is held under a valid/ready handshake until the core-side controller accepts it.

## Interface
- No parameters. Widths are fixed by FIPS 180-4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_data` in 32: message word. First byte in bits [31:24].
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: padder can accept a word.
- `in_last` in 1: this word is the final word of the message.
- `in_bytes` in 3: valid bytes in the last word, 0..4. Upper bytes are valid, lower bytes are ignored. 0 is legal only for the empty message. Port exists only under `SHA256_PADDER_BYTES_EN`.
- `block` out [0:511]: padded block. Word i occupies bits [32*i +: 32].
- `block_valid` out 1: `block` is complete and stable.
- `block_ready` in 1: consumer takes `block` this cycle.
- `block_last` out 1: this block is the final block of the message.

## Operation
- Buffer: 16×32 word registers plus a 4-bit word index `widx`.
- Length counter: 64-bit `bitlen`. On each accepted word, add 8×bytes; the sum wraps modulo 2^64.
- FSM states:
  - **FILL**: `in_ready` = 1.
    - Accepted non-last word goes to `buf[widx]`, then `widx`++.
    - When `widx` reaches 15 with a non-last word: go to EMIT with `pend` = NONE.
    - On a last word with b bytes: mask off the invalid low bytes and insert 0x80 at byte position b. If b = 4, the 0x80 goes into the next word; if that word would be word 16, it is deferred.
    - Let P = 4*widx + b, the byte offset of the 0x80.
    - If P ≤ 55 and the 0x80 fits in this block: zero-fill to word 13, write `bitlen` (including this word) into words 14–15, set `block_last` = 1, `pend` = NONE.
    - Else if the 0x80 fits (P ≤ 63): zero-fill to word 15, `pend` = LENONLY.
    - Else (P = 64): `pend` = PADLEN.
    - Then go to EMIT.
  - **EMIT**: `block_valid` = 1 and `in_ready` = 0. On `block_ready`:
    - `pend` = NONE and `block_last`: go to FILL and clear `bitlen`.
    - `pend` = NONE and not last: go to FILL.
    - `pend` = LENONLY: load a block of words 0–13 zero and length in words 14–15; go to EMIT with `block_last` = 1.
    - `pend` = PADLEN: same as LENONLY, but word 0 = 0x80000000.
  - `widx` clears on every transition into FILL.
- `block` is a direct register output and does not change while `block_valid` = 1.

## Timing
- Reset values: `in_ready` = 0 while reset is asserted and 1 in the first cycle after. All other outputs are 0: `block_valid`, `block_last`, `block`. Internal state: FSM = FILL, `bitlen` = 0.
- A block completed by the word accepted at edge N has `block_valid` = 1 in cycle N+1.
- A pending extra block is presented in the cycle after the handshake of the previous block.
- Handshake is not combinational: `in_ready` does not depend on `in_valid`, and `block_valid` does not depend on `block_ready`.
- Throughput: one word per cycle, plus one EMIT cycle per block when `block_ready` is held at 1.
- Reset asserted mid-message discards all partial and pending data asynchronously. No block is emitted.
- `in_valid` is ignored when `in_ready` = 0. A word is never lost and never duplicated.

## Configuration
- `SHA256_PADDER_BYTES_EN` defined:
  - `in_bytes` port exists, allowing byte-granular message lengths, including the empty message.
  - A last word with `in_bytes` > 4 is treated as 4.
- `SHA256_PADDER_BYTES_EN` undefined:
  - No `in_bytes` port. Every word is a full 4 bytes.
  - P is always a multiple of 4, so the empty message is not representable.

## Structure
- Package `sha256_pkg` holds:
  - `BLOCK_W` = 512, `WORDS` = 16, `PAD_BYTE` = 8'h80.
  - Typedef `pad_state_t` {FILL, EMIT}.
  - Typedef `pend_t` {NONE, LENONLY, PADLEN}.
- One sub-module, `sha256_last_word`: a combinational unit that takes a word and b and returns the masked word with 0x80 inserted, plus a carry flag when b = 4.

## Test plan
- "abc" as one last word 0x61626300 with `in_bytes` = 3 → one block:
  - word0 = 0x61626380, words 1–14 = 0, word15 = 0x00000018, `block_last` = 1.
  - Fed to the core, it yields hash ba7816bf…f20015ad.
- 14 full words (56 bytes), last on word 13:
  - Block 1: word14 = 0x80000000, word15 = 0, `block_last` = 0.
  - Block 2: zeros, word15 = 0x000001C0, `block_last` = 1.
- 16 full words (64 bytes):
  - Block 1 is pure data.
  - Block 2: word0 = 0x80000000, word15 = 0x00000200.
- Empty message, `in_bytes` = 0 → word0 = 0x80000000, all other words 0, `block_last` = 1.
- Backpressure: `block_ready` = 0 for 10 cycles → `block` is bit-stable, `in_ready` = 0, and no input word is consumed during the stall.
- Reset pulsed after 7 words:
  - `block_valid` stays 0.
  - A subsequent "abc" produces exactly the single-block result of the first scenario.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared widths and state types for the SHA-256 message padder and its helpers.
package sha256_pkg;

  localparam int         BLOCK_W  = 512;
  localparam int         WORDS    = 16;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic {
    FILL,
    EMIT
  } pad_state_t;

  // Work still owed after the current block is handed over.
  typedef enum logic [1:0] {
    NONE,
    LENONLY,
    PADLEN
  } pend_t;

endpackage

// File: rtl/sha256_last_word.sv
// Masks the unused low bytes of a message's final word and inserts the 0x80 pad byte.
module sha256_last_word
  import sha256_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  nbytes,
  output logic [31:0] padded,
  output logic        carry
);

  // A full final word leaves no room, so the pad byte spills into the following word.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    padded = word;
    carry  = 1'b0;
    case (nbytes)
      3'd0:    padded = {PAD_BYTE, 24'h0};
      3'd1:    padded = {word[31:24], PAD_BYTE, 16'h0};
      3'd2:    padded = {word[31:16], PAD_BYTE, 8'h0};
      3'd3:    padded = {word[31:8], PAD_BYTE};
      default: carry  = 1'b1;
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// Streams 32-bit big-endian message words into padded 512-bit SHA-256 blocks.
// Define SHA256_PADDER_BYTES_EN to add the in_bytes port for byte-granular lengths.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
`ifdef SHA256_PADDER_BYTES_EN
  input  logic [2:0]         in_bytes,
`endif
  output logic [0:BLOCK_W-1] block,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_last
);

  pad_state_t  state_q, state_d;
  pend_t       pend_q, pend_d;
  logic        last_q, last_d;
  logic [3:0]  widx_q, widx_d;
  logic [63:0] bitlen_q, bitlen_d, bitlen_sum;
  logic [31:0] wbuf_q [WORDS];
  logic [31:0] wbuf_d [WORDS];
  logic [2:0]  nbytes;
  logic [6:0]  pad_pos;
  logic [31:0] lw_word;
  logic        lw_carry;

  // Only the final word may be short; everything before it counts as four bytes.
`ifdef SHA256_PADDER_BYTES_EN
  assign nbytes = !in_last ? 3'd4 : (in_bytes > 3'd4) ? 3'd4 : in_bytes;
`else
  assign nbytes = 3'd4;
`endif

  assign bitlen_sum = bitlen_q + {58'd0, nbytes, 3'b000};
  assign pad_pos    = {1'b0, widx_q, 2'b00} + {4'd0, nbytes};

  sha256_last_word u_last_word (
    .word   (in_data),
    .nbytes (nbytes),
    .padded (lw_word),
    .carry  (lw_carry)
  );

  assign in_ready    = (state_q == FILL) && !reset;
  assign block_valid = (state_q == EMIT);
  assign block_last  = last_q;

  for (genvar i = 0; i < WORDS; i++) begin : g_block
    assign block[32*i +: 32] = wbuf_q[i];
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    last_d   = last_q;
    widx_d   = widx_q;
    bitlen_d = bitlen_q;
    wbuf_d   = wbuf_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          bitlen_d = bitlen_sum;
          if (!in_last) begin
            wbuf_d[widx_q] = in_data;
            if (widx_q == 4'd15) begin
              state_d = EMIT;
              pend_d  = NONE;
              last_d  = 1'b0;
            end else begin
              widx_d = widx_q + 4'd1;
            end
          end else begin
            wbuf_d[widx_q] = lw_word;
            for (int i = 0; i < WORDS; i++) begin
              if (i > int'(widx_q)) wbuf_d[i] = '0;
            end
            if (lw_carry && widx_q != 4'd15) wbuf_d[widx_q + 4'd1] = {PAD_BYTE, 24'h0};
            state_d = EMIT;
            if (pad_pos <= 7'd55) begin
              wbuf_d[14] = bitlen_sum[63:32];
              wbuf_d[15] = bitlen_sum[31:0];
              last_d     = 1'b1;
              pend_d     = NONE;
            end else if (pad_pos <= 7'd63) begin
              last_d = 1'b0;
              pend_d = LENONLY;
            end else begin
              last_d = 1'b0;
              pend_d = PADLEN;
            end
          end
        end
      end
      EMIT: begin
        if (block_ready) begin
          if (pend_q == NONE) begin
            state_d = FILL;
            widx_d  = '0;
            last_d  = 1'b0;
            if (last_q) bitlen_d = '0;
          end else begin
            // Trailing length-only block; PADLEN also carries the deferred pad byte.
            for (int i = 0; i < WORDS; i++) wbuf_d[i] = '0;
            if (pend_q == PADLEN) wbuf_d[0] = {PAD_BYTE, 24'h0};
            wbuf_d[14] = bitlen_q[63:32];
            wbuf_d[15] = bitlen_q[31:0];
            last_d     = 1'b1;
            pend_d     = NONE;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      pend_q   <= NONE;
      last_q   <= 1'b0;
      widx_q   <= '0;
      bitlen_q <= '0;
      // NOTE: the word buffer is reset because it drives the block output directly.
      for (int i = 0; i < WORDS; i++) wbuf_q[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q  <= state_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      widx_q   <= widx_d;
      bitlen_q <= bitlen_d;
      wbuf_q   <= wbuf_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: a byte-level FIPS 180-4 padding model feeds a
// block scoreboard; directed messages cover padding boundaries, backpressure and reset.
module tb_sha256_padder;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;
  typedef blk_t blk_q_t[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_last = 1'b0;
`ifdef SHA256_PADDER_BYTES_EN
  logic [2:0]   in_bytes = '0;
`endif
  logic [0:511] block;
  logic         block_valid;
  logic         block_ready = 1'b1;
  logic         block_last;

  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_words = 0;
  int   exp_words = 0;
  blk_t exp_q[$];
  blk_t cur_exp;
  bit   prev_last_acc = 1'b0;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
`ifdef SHA256_PADDER_BYTES_EN
    .in_bytes    (in_bytes),
`endif
    .block       (block),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [511:0] b, input int i);
    return b[511-32*i -: 32];
  endfunction

  function automatic int words_of(input int n);
    return (n == 0) ? 1 : (n + 3) / 4;
  endfunction

  // Padding straight from the byte-level definition: append 0x80, zero to 56 mod 64, length.
  task automatic model(input byte_q_t msg, output blk_q_t blks);
    byte_q_t         m;
    longint unsigned bl;
    logic [511:0]    d;
    int              nb;
    m  = msg;
    bl = 64'(msg.size()) * 8;
    m.push_back(8'h80);
    while (m.size() % 64 != 56) m.push_back(8'h00);
    for (int i = 7; i >= 0; i--) m.push_back(8'(bl >> (8 * i)));
    nb   = m.size() / 64;
    blks = {};
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int j = 0; j < 64; j++) d[511-8*j -: 8] = m[64*b+j];
      blks.push_back('{data: d, last: (b == nb - 1)});
    end
  endtask

  task automatic make_msg(input int n, input int seed, output byte_q_t q);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(8'(seed + 13 * k + 1));
  endtask

  task automatic send(input byte_q_t msg, input bit terminate, input bit clamp);
    int          n;
    int          nw;
    int          t;
    logic [31:0] w;
    n  = msg.size();
    nw = words_of(n);
    for (int i = 0; i < nw; i++) begin
      w = 32'hEEEE_EEEE;
      for (int k = 0; k < 4; k++) if (4 * i + k < n) w[31-8*k -: 8] = msg[4*i+k];
      in_data  = w;
      in_valid = 1'b1;
      in_last  = terminate && (i == nw - 1);
`ifdef SHA256_PADDER_BYTES_EN
      if (in_last) in_bytes = (n - 4 * i >= 4) ? (clamp ? 3'd7 : 3'd4) : 3'(n - 4 * i);
      else         in_bytes = 3'd0;
`endif
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input byte_q_t msg, input blk_q_t blks, input bit clamp);
    foreach (blks[i]) exp_q.push_back(blks[i]);
    exp_words += words_of(msg.size());
    send(msg, 1'b1, clamp);
    wait_drain();
  endtask

  task automatic run_abc(input string tag);
    byte_q_t msg;
    blk_q_t  blks;
`ifdef SHA256_PADDER_BYTES_EN
    msg = {8'h61, 8'h62, 8'h63};
    model(msg, blks);
    check({tag, "_model_n"}, blks.size(), 1);
    check({tag, "_model_blk"}, blks[0].data, {32'h6162_6380, 448'h0, 32'h0000_0018});
`else
    msg = {8'h61, 8'h62, 8'h63, 8'h64};
    model(msg, blks);
    check({tag, "_model_n"}, blks.size(), 1);
    check({tag, "_model_blk"}, blks[0].data, {32'h6162_6364, 32'h8000_0000, 416'h0, 32'h0000_0020});
`endif
    check({tag, "_model_last"}, blks[0].last, 1);
    go(msg, blks, 1'b0);
  endtask

  task automatic stall_watch();
    int           t;
    int           snap_acc;
    logic [511:0] snap;
    t = 0;
    @(negedge clk);
    while (!block_valid && t < 200) begin
      t++;
      @(negedge clk);
    end
    check("stall_valid", block_valid, 1);
    snap     = block;
    snap_acc = acc_words;
    repeat (10) begin
      @(negedge clk);
      check("stall_block", block, snap);
      check("stall_in_ready", in_ready, 0);
      check("stall_no_accept", acc_words, snap_acc);
    end
    @(posedge clk);
    #1 block_ready = 1'b1;
  endtask

  // Scoreboard: every presented block is compared at its handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_last_acc = 1'b0;
    end else begin
      if (prev_last_acc) check("latency_last", block_valid, 1);
      check("ready_vs_valid", in_ready, !block_valid);
      if (block_valid && exp_q.size() == 0) begin
        check("unexpected_block", block_valid, 0);
      end else if (block_valid && block_ready) begin
        cur_exp = exp_q.pop_front();
        check("block_data", block, cur_exp.data);
        check("block_last", block_last, cur_exp.last);
      end
      if (in_valid && in_ready) acc_words++;
      prev_last_acc = in_valid && in_ready && in_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t msg;
    blk_q_t  blks;

    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_block_valid", block_valid, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("init_in_ready", in_ready, 1);
    check("init_block_valid", block_valid, 0);
    check("init_block_last", block_last, 0);
    check("init_block", block, 0);
    @(posedge clk);
    #1;

    run_abc("abc");

    make_msg(56, 3, msg);
    model(msg, blks);
    check("m56_n", blks.size(), 2);
    check("m56_b0_w14", wd(blks[0].data, 14), 32'h8000_0000);
    check("m56_b0_w15", wd(blks[0].data, 15), 0);
    check("m56_b0_last", blks[0].last, 0);
    check("m56_b1", blks[1].data, {480'h0, 32'h0000_01C0});
    check("m56_b1_last", blks[1].last, 1);
    go(msg, blks, 1'b0);

    make_msg(64, 7, msg);
    model(msg, blks);
    check("m64_n", blks.size(), 2);
    check("m64_b1", blks[1].data, {32'h8000_0000, 448'h0, 32'h0000_0200});
    go(msg, blks, 1'b1);

`ifdef SHA256_PADDER_BYTES_EN
    msg = {};
    model(msg, blks);
    check("empty_n", blks.size(), 1);
    check("empty_blk", blks[0].data, {32'h8000_0000, 480'h0});
    go(msg, blks, 1'b0);

    make_msg(55, 11, msg);
    model(msg, blks);
    check("m55_n", blks.size(), 1);
    check("m55_w13_pad", wd(blks[0].data, 13) & 32'hFF, 32'h80);
    check("m55_w15", wd(blks[0].data, 15), 32'h0000_01B8);
    go(msg, blks, 1'b0);

    make_msg(63, 17, msg);
    model(msg, blks);
    check("m63_n", blks.size(), 2);
    check("m63_b0_w15_pad", wd(blks[0].data, 15) & 32'hFF, 32'h80);
    check("m63_b1", blks[1].data, {480'h0, 32'h0000_01F8});
    go(msg, blks, 1'b0);
`endif

    make_msg(68, 5, msg);
    model(msg, blks);
    check("m68_n", blks.size(), 2);
    check("m68_b1_w1", wd(blks[1].data, 1), 32'h8000_0000);
    check("m68_b1_w15", wd(blks[1].data, 15), 32'h0000_0220);
    foreach (blks[i]) exp_q.push_back(blks[i]);
    exp_words += 17;
    block_ready = 1'b0;
    fork
      send(msg, 1'b1, 1'b0);
      stall_watch();
    join
    wait_drain();

    make_msg(28, 9, msg);
    exp_words += 7;
    send(msg, 1'b0, 1'b0);
    #2 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_block_valid", block_valid, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_valid", block_valid, 0);
      check("post_rst_block", block, 0);
    end
    @(posedge clk);
    #1;
    run_abc("abc_after_rst");

    check("words_accepted", acc_words, exp_words);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
